// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer and the 16-bit datapath.
//   state_t   : sequencer states
//   OP_*      : opcodes in IR[15:12] (opcodes 0xxx are register ALU ops)
//   FS_*      : datapath function-select codes
//   ctrwrd_t  : control word layout {DA,AA,BA,MB,FS,MD,RW}
package cpu_pkg;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_BRANCH = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_LD   = 4'b1001;
  localparam logic [3:0] OP_ST   = 4'b1010;
  localparam logic [3:0] OP_LDI  = 4'b1011;
  localparam logic [3:0] OP_BRZ  = 4'b1100;
  localparam logic [3:0] OP_BRN  = 4'b1101;
  localparam logic [3:0] OP_JMP  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] FS_PASSA = 4'b0000;
  localparam logic [3:0] FS_ADD   = 4'b0010;
  localparam logic [3:0] FS_PASSB = 4'b1100;

  // Control word bit positions (LSB of each field)
  localparam int CW_DA_LSB = 13;
  localparam int CW_AA_LSB = 10;
  localparam int CW_BA_LSB = 7;
  localparam int CW_MB     = 6;
  localparam int CW_FS_LSB = 2;
  localparam int CW_MD     = 1;
  localparam int CW_RW     = 0;

  typedef struct packed {
    logic [2:0] da;
    logic [2:0] aa;
    logic [2:0] ba;
    logic       mb;
    logic [3:0] fs;
    logic       md;
    logic       rw;
  } ctrwrd_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decode.
//   ir        in  16  instruction register {OP,DR,SA,SB,IMM}
//   ctrwrd    out 16  datapath control word for the EXEC cycle
//   cin       out 16  zero-extended IMM
//   mw        out 1   data-memory write (ST)
//   is_branch out 1   BRZ or BRN
//   is_jmp    out 1   JMP
//   is_halt   out 1   HALT
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [15:0] ctrwrd,
  output logic [15:0] cin,
  output logic        mw,
  output logic        is_branch,
  output logic        is_jmp,
  output logic        is_halt
);

  ctrwrd_t    cw;
  logic [3:0] op;

  assign op     = ir[15:12];
  assign ctrwrd = cw;
  assign cin    = {13'd0, ir[2:0]};

  always_comb begin
    cw.da     = ir[11:9];
    cw.aa     = ir[8:6];
    cw.ba     = ir[5:3];
    cw.mb     = 1'b0;
    cw.fs     = FS_PASSA;
    cw.md     = 1'b0;
    cw.rw     = 1'b0;
    mw        = 1'b0;
    is_branch = 1'b0;
    is_jmp    = 1'b0;
    is_halt   = 1'b0;
    if (!op[3]) begin
      cw.fs = {1'b0, op[2:0]};
      cw.rw = 1'b1;
    end else begin
      case (op)
        OP_ADDI: begin
          cw.mb = 1'b1;
          cw.fs = FS_ADD;
          cw.rw = 1'b1;
        end
        OP_LD: begin
          cw.md = 1'b1;
          cw.rw = 1'b1;
        end
        OP_ST:   mw = 1'b1;
        OP_LDI: begin
          cw.mb = 1'b1;
          cw.fs = FS_PASSB;
          cw.rw = 1'b1;
        end
        // PASSA exposes R[SA] so the datapath updates Z/N for the BRANCH cycle
        OP_BRZ, OP_BRN: is_branch = 1'b1;
        OP_JMP:  is_jmp  = 1'b1;
        OP_HALT: is_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode sequencer driving the 16-bit datapath.
//   CLK, RESET        clock, synchronous active-high reset
//   IM_REQ/IM_ADDR    instruction fetch request and address (= PC)
//   IM_ACK/IM_DATA    fetch acknowledge and instruction
//   CTRWRD, Cin, MW   datapath control word, constant, memory write
//   ADRIN             datapath Adrout, JMP target
//   V, C, N, Z        datapath flags (N/Z resolve branches)
//   HALTED            high in HALT
//
// state    | meaning
// ---------+---------------------------------------------------
// S_FETCH  | request IR at PC; on IM_ACK load IR, PC+1
// S_EXEC   | drive decoded control word for one cycle
// S_BRANCH | test Z (BRZ) or N (BRN), apply 6-bit PC offset
// S_HALT   | idle until RESET
module control_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  output logic            IM_REQ,
  output logic [PC_W-1:0] IM_ADDR,
  input  logic            IM_ACK,
  input  logic [15:0]     IM_DATA,
  output logic [15:0]     CTRWRD,
  output logic [15:0]     Cin,
  input  logic [15:0]     ADRIN,
  input  logic            V,
  input  logic            C,
  input  logic            N,
  input  logic            Z,
  output logic            MW,
  output logic            HALTED
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic            br_on_n;
  logic [15:0]     dec_ctrwrd;
  logic [15:0]     dec_cin;
  logic            dec_mw, dec_branch, dec_jmp, dec_halt;
  logic [5:0]      br_off6;
  logic [PC_W-1:0] br_off;
  logic            br_taken;
  logic            unused_inputs;

  assign unused_inputs = ^{V, C, ADRIN};

  instr_decoder u_dec (
    .ir        (ir),
    .ctrwrd    (dec_ctrwrd),
    .cin       (dec_cin),
    .mw        (dec_mw),
    .is_branch (dec_branch),
    .is_jmp    (dec_jmp),
    .is_halt   (dec_halt)
  );

  // Branch offset is {DR,SB}, relative to the already-incremented PC
  assign br_off6  = {ir[11:9], ir[5:3]};
  assign br_off   = {{(PC_W-6){br_off6[5]}}, br_off6};
  assign br_taken = br_on_n ? N : Z;

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (IM_ACK) state_nxt = S_EXEC;
      S_EXEC: begin
        if (dec_branch)    state_nxt = S_BRANCH;
        else if (dec_halt) state_nxt = S_HALT;
        else               state_nxt = S_FETCH;
      end
      S_BRANCH: state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc      <= RESET_PC;
      ir      <= '0;
      br_on_n <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (IM_ACK) begin
            ir <= IM_DATA;
            pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
          end
        end
        S_EXEC: begin
          if (dec_jmp)    pc      <= ADRIN[PC_W-1:0];
          if (dec_branch) br_on_n <= ir[12];
        end
        S_BRANCH: if (br_taken) pc <= pc + br_off;
        default: ;
      endcase
    end
  end

  always_comb begin
    IM_REQ  = (state == S_FETCH) && !RESET;
    IM_ADDR = pc;
    CTRWRD  = (state == S_EXEC) ? dec_ctrwrd : 16'h0000;
    MW      = (state == S_EXEC) ? dec_mw : 1'b0;
    Cin     = dec_cin;
    HALTED  = (state == S_HALT);
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        CLK;
  logic        RESET;
  logic        IM_REQ;
  logic [15:0] IM_ADDR;
  logic        IM_ACK;
  logic [15:0] IM_DATA;
  logic [15:0] CTRWRD;
  logic [15:0] Cin;
  logic [15:0] ADRIN;
  logic        V, C, N, Z;
  logic        MW;
  logic        HALTED;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int pc_m    = 0;

  control_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .IM_REQ  (IM_REQ),
    .IM_ADDR (IM_ADDR),
    .IM_ACK  (IM_ACK),
    .IM_DATA (IM_DATA),
    .CTRWRD  (CTRWRD),
    .Cin     (Cin),
    .ADRIN   (ADRIN),
    .V       (V),
    .C       (C),
    .N       (N),
    .Z       (Z),
    .MW      (MW),
    .HALTED  (HALTED)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode: control word built arithmetically from field weights
  function automatic logic [15:0] model_cw(input logic [15:0] ins);
    int op, mb, fs, md, rw, v;
    op = int'(ins[15:12]);
    mb = 0; fs = 0; md = 0; rw = 0;
    if (op < 8) begin fs = op; rw = 1; end
    else if (op == 8)  begin mb = 1; fs = 2;  rw = 1; end
    else if (op == 9)  begin md = 1; rw = 1; end
    else if (op == 11) begin mb = 1; fs = 12; rw = 1; end
    v = int'(ins[11:9]) * 8192 + int'(ins[8:6]) * 1024 + int'(ins[5:3]) * 128
      + mb * 64 + fs * 4 + md * 2 + rw;
    return 16'(v);
  endfunction

  // One full instruction: wt wait cycles, fetch, EXEC, optional BRANCH.
  task automatic run_instr(input logic [15:0] ins, input int wt, input logic z, input logic n,
                           input logic [15:0] adr, input logic use_dir, input logic [15:0] dir_cw);
    int op, off;
    op = int'(ins[15:12]);
    for (int i = 0; i < wt; i++) begin
      IM_ACK = 1'b0; IM_DATA = 16'(($urandom));
      #1;
      chk("wait_req", {15'd0, IM_REQ}, 16'd1);
      chk("wait_addr", IM_ADDR, 16'(pc_m));
      chk("wait_cw", CTRWRD, 16'h0000);
      chk("wait_mw", {15'd0, MW}, 16'd0);
      tick();
    end
    IM_ACK = 1'b1; IM_DATA = ins;
    #1;
    chk("fetch_req", {15'd0, IM_REQ}, 16'd1);
    chk("fetch_addr", IM_ADDR, 16'(pc_m));
    chk("fetch_cw", CTRWRD, 16'h0000);
    tick();
    // EXEC: a stray ack here must be ignored
    IM_ACK = 1'($urandom); IM_DATA = 16'($urandom); ADRIN = adr;
    Z = 1'($urandom); N = 1'($urandom);
    #1;
    chk("exec_cw", CTRWRD, model_cw(ins));
    if (use_dir) chk("exec_cw_dir", CTRWRD, dir_cw);
    chk("exec_mw", {15'd0, MW}, (op == 10) ? 16'd1 : 16'd0);
    chk("exec_cin", Cin, {13'd0, ins[2:0]});
    chk("exec_req", {15'd0, IM_REQ}, 16'd0);
    chk("exec_halted", {15'd0, HALTED}, 16'd0);
    pc_m = (pc_m + 1) % 65536;
    tick();
    if (op == 14) pc_m = int'(adr);
    if (op == 12 || op == 13) begin
      IM_ACK = 1'($urandom); Z = z; N = n;
      #1;
      chk("branch_cw", CTRWRD, 16'h0000);
      chk("branch_req", {15'd0, IM_REQ}, 16'd0);
      off = int'({ins[11:9], ins[5:3]});
      if (off >= 32) off = off - 64;
      if ((op == 12) ? z : n) pc_m = (pc_m + off + 65536) % 65536;
      tick();
    end
    IM_ACK = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; IM_ACK = 1'b0; IM_DATA = 16'h0; ADRIN = 16'h0;
    V = 1'b0; C = 1'b0; N = 1'b0; Z = 1'b0;

    // Reset, then zero-wait fetch of ALU op 001
    tick(); tick();
    IM_ACK = 1'b1;
    #1;
    chk("reset_req", {15'd0, IM_REQ}, 16'd0);
    chk("reset_halted", {15'd0, HALTED}, 16'd0);
    chk("reset_cw", CTRWRD, 16'h0000);
    chk("reset_addr", IM_ADDR, 16'h0000);
    RESET = 1'b0;
    pc_m = 0;
    run_instr(16'h1A53, 0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hA505);
    #1;
    chk("next_addr", IM_ADDR, 16'h0001);

    // Wait states, ADDI, ST
    run_instr(16'h0A53, 3, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    run_instr(16'h8645, 1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h6449);
    run_instr(16'hA088, 0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0880);

    // BRZ at PC=10, offset -3: taken and not taken
    run_instr(16'hE000, 0, 1'b0, 1'b0, 16'd10, 1'b0, 16'h0);
    run_instr(16'hCE28, 0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    chk("brz_taken_addr", IM_ADDR, 16'd8);
    run_instr(16'hE000, 2, 1'b0, 1'b0, 16'd10, 1'b0, 16'h0);
    run_instr(16'hCE28, 0, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0);
    #1;
    chk("brz_nt_addr", IM_ADDR, 16'd11);

    // JMP to FFFF, then PC wraps to 0000
    run_instr(16'hE000, 0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 16'h0);
    #1;
    chk("jmp_addr", IM_ADDR, 16'hFFFF);
    run_instr(16'h3000, 0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    chk("wrap_addr", IM_ADDR, 16'h0000);

    // Randomised program against the reference model
    for (int k = 0; k < 200; k++) begin
      logic [15:0] r;
      r = 16'($urandom);
      r[15:12] = 4'($urandom_range(0, 14));
      run_instr(r, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                16'($urandom), 1'b0, 16'h0);
    end

    // Reset during a fetch wait
    run_instr(16'hE000, 0, 1'b0, 1'b0, 16'h0020, 1'b0, 16'h0);
    IM_ACK = 1'b0;
    #1;
    chk("rfetch_req_pre", {15'd0, IM_REQ}, 16'd1);
    tick();
    RESET = 1'b1; IM_ACK = 1'b1; IM_DATA = 16'h1A53;
    #1;
    chk("rfetch_req_rst", {15'd0, IM_REQ}, 16'd0);
    tick();
    RESET = 1'b0; IM_ACK = 1'b0; pc_m = 0;
    #1;
    chk("rfetch_addr", IM_ADDR, 16'h0000);
    chk("rfetch_req_post", {15'd0, IM_REQ}, 16'd1);

    // Reset during BRANCH suppresses the taken PC update
    run_instr(16'hE000, 0, 1'b0, 1'b0, 16'h0030, 1'b0, 16'h0);
    IM_ACK = 1'b1; IM_DATA = 16'hCE28;
    tick();
    IM_ACK = 1'b0;
    tick();
    RESET = 1'b1; Z = 1'b1;
    #1;
    chk("rbr_cw", CTRWRD, 16'h0000);
    chk("rbr_req", {15'd0, IM_REQ}, 16'd0);
    tick();
    RESET = 1'b0; pc_m = 0;
    #1;
    chk("rbr_addr", IM_ADDR, 16'h0000);

    // HALT is terminal until RESET
    run_instr(16'hF000, 1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      IM_ACK = 1'($urandom);
      #1;
      chk("halt_halted", {15'd0, HALTED}, 16'd1);
      chk("halt_req", {15'd0, IM_REQ}, 16'd0);
      chk("halt_cw", CTRWRD, 16'h0000);
      chk("halt_mw", {15'd0, MW}, 16'd0);
      tick();
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0; IM_ACK = 1'b0;
    #1;
    chk("unhalt_halted", {15'd0, HALTED}, 16'd0);
    chk("unhalt_addr", IM_ADDR, 16'h0000);
    chk("unhalt_req", {15'd0, IM_REQ}, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle instruction sequencer that sits directly upstream of the 16-bit register/function-unit datapath.
- Fetches 16-bit instructions over a request/acknowledge instruction-memory port and decodes each one into the datapath control word (CTRWRD) and constant (Cin).
- Drives data-memory write strobe MW.
- Consumes the datapath status flags (Z, N) and address bus (Adrout) to resolve conditional branches and jumps.

Parameters:
- PC_W, 16, program-counter and IM_ADDR width.
- RESET_PC, 0, PC value loaded on RESET.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- IM_REQ  out  1  instruction fetch request.
- IM_ADDR  out  PC_W  fetch address; equals PC.
- IM_ACK  in  1  IM_DATA valid this cycle.
- IM_DATA  in  16  fetched instruction.
- CTRWRD  out  16  control word {DA[15:13],AA[12:10],BA[9:7],MB[6],FS[5:2],MD[1],RW[0]}.
- Cin  out  16  constant for datapath B-mux; zero-extended IR[2:0].
- ADRIN  in  16  datapath Adrout (R[SA]); JMP target.
- V  in  1  datapath overflow flag; unused.
- C  in  1  datapath carry flag; unused.
- N  in  1  datapath negative flag.
- Z  in  1  datapath zero flag.
- MW  out  1  data-memory write strobe (address = Adrout, data = Dout).
- HALTED  out  1  high in HALT state.

Behaviour:
- IR format: OP[15:12], DR[11:9], SA[8:6], SB[5:3], IMM[2:0].
- States: FETCH, EXEC, BRANCH, HALT. RESET forces FETCH, PC=RESET_PC, IR=0, flag latch cleared.
- Outside EXEC: CTRWRD=16'h0000 (RW=0, a no-op), MW=0. IM_REQ=1 only in FETCH and never while RESET=1. HALTED=0 except in HALT.
- IM_ACK while RESET=1 or outside FETCH is ignored.
- FETCH:
  - IM_REQ=1; IM_ADDR=PC held stable until IM_ACK.
  - On IM_ACK: IR<=IM_DATA, PC<=PC+1 (mod 2^PC_W), go to EXEC.
  - Zero-wait memory (IM_ACK same cycle) is legal. Fetch latency = 1 + wait cycles.
- EXEC (exactly one cycle): CTRWRD decoded combinationally from IR; DA=DR, AA=SA, BA=SB unless stated otherwise.
  - OP=0xxx, ALU reg: MB=0, FS={0,OP[2:0]}, MD=0, RW=1.
  - 1000 ADDI: MB=1, FS=FS_ADD, RW=1.
  - 1001 LD: MD=1, RW=1. The datapath writes Din.
  - 1010 ST: RW=0, MW=1.
  - 1011 LDI: MB=1, FS=FS_PASSB, RW=1.
  - 1100 BRZ and 1101 BRN: FS=FS_PASSA, RW=0; next state BRANCH.
  - 1110 JMP: RW=0, PC<=ADRIN[PC_W-1:0].
  - 1111 HALT: RW=0; next state HALT.
  - All other opcodes return to FETCH.
- BRANCH (one cycle):
  - Taken condition: Z for BRZ, N for BRN, sampled this cycle. These are the flags the datapath produced from the EXEC test.
  - Taken: PC<=PC+sext({DR,SB}), a 6-bit offset relative to the already-incremented PC, modulo 2^PC_W.
  - Go to FETCH.
- HALT: terminal; only RESET exits.
- Reset mid-fetch or mid-branch: the pending operation is abandoned and the PC update is suppressed.
- Cycles per instruction: 2 + wait (ALU/LD/ST/JMP); 3 + wait (branches).

Decomposition:
- Shared package cpu_pkg holds:
  - state enum;
  - opcode constants OP_ADDI..OP_HALT;
  - FS codes FS_PASSA=4'b0000, FS_ADD=4'b0010, FS_PASSB=4'b1100;
  - CTRWRD field bit positions.
- The datapath reuses the same package.
- One natural sub-module: instr_decoder, purely combinational IR -> {CTRWRD, Cin, MW, is_branch, is_jmp, is_halt}. The FSM and PC live in control_unit.

Test Plan:
- Reset/fetch: RESET 1 cycle, IM_ACK tied 1, IM_DATA=16'h1A53 (ALU op 001) -> IM_ADDR=0, then EXEC CTRWRD={DA=5,AA=1,BA=2,MB=0,FS=0001,MD=0,RW=1}; next IM_ADDR=1.
- Wait states: IM_ACK delayed 3 cycles -> IM_REQ high, IM_ADDR stable for 4 cycles, CTRWRD=0 throughout, single EXEC afterwards.
- Immediate/memory: ADDI R3,R1,#5 -> MB=1, Cin=16'h0005, FS=0010, RW=1. ST R1->[R2] -> MW=1, RW=0 for exactly one cycle.
- Branch: BRZ at PC=10 with offset -3 and Z=1 in BRANCH -> next IM_ADDR=8. With Z=0 -> next IM_ADDR=11.
- JMP/wrap: JMP with ADRIN=16'hFFFF -> fetch at FFFF, next fetch address 0000.
- HALT/reset: HALT -> HALTED=1, IM_REQ=0 indefinitely. RESET asserted during FETCH wait -> IM_REQ=0 that cycle, restart at RESET_PC.
